gate_net_pipe: RTL and testbench



---
 rtl/gate_net_pkg.sv | 40 ++++
 rtl/gate_net_lane.sv | 18 +
 rtl/gate_net_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_gate_net_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_net_pkg.sv
// -----------------------------------------------------------------------------
// gate_net_pkg
// Shared definitions for the pipelined gate-network evaluator:
//   - sweep FSM state encoding
//   - bit positions of a, b, c, d inside one 4-bit lane vector
//   - gate_net_f: the 4-input gate network equation
// -----------------------------------------------------------------------------
package gate_net_pkg;

    // Sweep engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Lane vector layout: {a, b, c, d}
    localparam int A_BIT = 3;
    localparam int B_BIT = 2;
    localparam int C_BIT = 1;
    localparam int D_BIT = 0;

    // Number of input combinations a sweep walks through per lane
    localparam int         SWEEP_LEN  = 16;
    localparam logic [3:0] SWEEP_LAST = 4'd15;

    // Gate network as drawn. The expression reduces to ~c & ~(a & d),
    // but it is kept in its original form so the block evaluates the
    // network exactly as it is specified for the family.
    function automatic logic gate_net_f(
        input logic a,
        input logic b,
        input logic c,
        input logic d
    );
        return (~(a & b) | ~(a & c)) & ~((a & d) | c);
    endfunction

endpackage

// File: rtl/gate_net_lane.sv
// -----------------------------------------------------------------------------
// gate_net_lane
// Single-lane combinational evaluator of the gate network.
// Ports:
//   abcd_i  [3:0]  lane vector, bit 3 = a, bit 2 = b, bit 1 = c, bit 0 = d
//   y_o            network output for this lane
// -----------------------------------------------------------------------------
module gate_net_lane
    import gate_net_pkg::*;
(
    input  logic [3:0] abcd_i,
    output logic       y_o
);

    assign y_o = gate_net_f(abcd_i[A_BIT], abcd_i[B_BIT],
                            abcd_i[C_BIT], abcd_i[D_BIT]);

endmodule

// File: rtl/gate_net_pipe.sv
// -----------------------------------------------------------------------------
// gate_net_pipe
// Multi-lane pipelined evaluator of the gate network with a built-in sweep
// engine that drives all 16 input combinations into every lane and reports
// how many lane results were 1.
//
// Parameters:
//   LANES  number of independent evaluation lanes (1..16)
//   PIPE   pipeline depth, input sample to output, in cycles (1..4)
//   CW     width of ones_count (derived)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     stream vector valid, ignored while a sweep is running
//   in_abcd      lane i vector at bits [4i+3:4i] = {a, b, c, d}
//   sweep_start  one-cycle sweep request, honoured only when idle
//   out_valid    y carries a fresh result (stream or sweep)
//   y            per-lane result, holds its last value while out_valid=0
//   sweep_busy   high from the first issue cycle through the DONE cycle
//   sweep_done   one-cycle pulse; ones_count is final in that cycle
//   ones_count   y=1 total of the last completed sweep
// -----------------------------------------------------------------------------
module gate_net_pipe
    import gate_net_pkg::*;
#(
    parameter int  LANES = 4,
    parameter int  PIPE  = 2,
    localparam int CW    = $clog2(16 * LANES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [4*LANES-1:0]   in_abcd,
    input  logic                 sweep_start,
    output logic                 out_valid,
    output logic [LANES-1:0]     y,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [CW-1:0]        ones_count
);

    localparam int LW = 4 * LANES;

    // Sweep engine state
    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [1:0]       drain_q;
    logic [CW-1:0]    acc_q;
    logic [CW-1:0]    ones_q;
    logic             busy_q;
    logic             done_q;

    // Pipeline: data, valid and sweep tag travel together
    logic [LW-1:0]    data_q [PIPE];
    logic [PIPE-1:0]  vld_q;
    logic [PIPE-1:0]  tag_q;

    // Last presented result, so y is stable between valid outputs
    logic [LANES-1:0] y_hold_q;

    logic [LW-1:0]    sweep_vec_s;
    logic [LW-1:0]    s0_data_s;
    logic             s0_vld_s;
    logic             s0_tag_s;
    logic [LW-1:0]    final_data_s;
    logic [LANES-1:0] y_eval_s;
    logic             sweep_hit_s;
    logic [CW-1:0]    acc_d;

    // Number of set bits in one cycle's lane results
    function automatic logic [CW-1:0] popcount_f(input logic [LANES-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            n = n + {{(CW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Sweep vector: lane i sees (cnt + i) mod 16, so over 16 issues
    // every lane covers every combination exactly once.
    always_comb begin
        sweep_vec_s = {LW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sweep_vec_s[4*i +: 4] = cnt_q + 4'(i);
        end
    end

    // Stage-0 source select: stream when idle, sweep vectors while issuing,
    // nothing while draining or reporting.
    always_comb begin
        s0_data_s = in_abcd;
        s0_vld_s  = 1'b0;
        s0_tag_s  = 1'b0;
        case (state_q)
            IDLE: begin
                s0_data_s = in_abcd;
                s0_vld_s  = in_valid;
                s0_tag_s  = 1'b0;
            end
            ISSUE: begin
                s0_data_s = sweep_vec_s;
                s0_vld_s  = 1'b1;
                s0_tag_s  = 1'b1;
            end
            DRAIN, DONE: begin
                s0_data_s = in_abcd;
                s0_vld_s  = 1'b0;
                s0_tag_s  = 1'b0;
            end
            default: begin
                s0_data_s = in_abcd;
                s0_vld_s  = 1'b0;
                s0_tag_s  = 1'b0;
            end
        endcase
    end

    // Non-stalling pipeline shift of data, valid and sweep tag
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= {PIPE{1'b0}};
            tag_q <= {PIPE{1'b0}};
            for (int s = 0; s < PIPE; s++) begin
                data_q[s] <= {LW{1'b0}};
            end
        end else begin
            vld_q[0]  <= s0_vld_s;
            tag_q[0]  <= s0_tag_s;
            data_q[0] <= s0_data_s;
            for (int s = 1; s < PIPE; s++) begin
                vld_q[s]  <= vld_q[s-1];
                tag_q[s]  <= tag_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign final_data_s = data_q[PIPE-1];

    // Per-lane evaluators on the final pipeline stage
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        gate_net_lane u_lane (
            .abcd_i (final_data_s[4*g +: 4]),
            .y_o    (y_eval_s[g])
        );
    end

    // Remember the last valid result so y holds while out_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            y_hold_q <= {LANES{1'b0}};
        end else if (vld_q[PIPE-1]) begin
            y_hold_q <= y_eval_s;
        end else begin
            y_hold_q <= y_hold_q;
        end
    end

    // Only results born from sweep vectors count; stream vectors that were
    // still in flight when the sweep began carry tag=0.
    assign sweep_hit_s = vld_q[PIPE-1] & tag_q[PIPE-1];

    // Accumulator next value including this cycle's sweep result
    always_comb begin
        if (sweep_hit_s) begin
            acc_d = acc_q + popcount_f(y_eval_s);
        end else begin
            acc_d = acc_q;
        end
    end

    // Sweep FSM with its counters, accumulator and registered status outputs.
    // ones_count is loaded on the DRAIN->DONE edge (the last sweep result is
    // on the output in that final DRAIN cycle), so it is already final while
    // sweep_done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            drain_q <= 2'd0;
            acc_q   <= {CW{1'b0}};
            ones_q  <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            acc_q  <= acc_d;
            case (state_q)
                IDLE: begin
                    acc_q   <= {CW{1'b0}};
                    cnt_q   <= 4'd0;
                    drain_q <= 2'd0;
                    if (sweep_start) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (cnt_q == SWEEP_LAST) begin
                        state_q <= DRAIN;
                        drain_q <= 2'd0;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (drain_q == 2'(PIPE - 1)) begin
                        state_q <= DONE;
                        ones_q  <= acc_d;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = vld_q[PIPE-1];
    assign y          = vld_q[PIPE-1] ? y_eval_s : y_hold_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_gate_net_pipe.sv
// -----------------------------------------------------------------------------
// tb_gate_net_pipe
// Scoreboard bench for gate_net_pipe. Stimulus pushes expected y values and
// expected sweep_done (cycle, ones_count) pairs into queues; a negedge
// monitor pops and compares whenever a DUT presents out_valid or sweep_done.
// Three instances: A (LANES=4, PIPE=2), B (LANES=1, PIPE=1),
// C (LANES=16, PIPE=4).
// -----------------------------------------------------------------------------
module tb_gate_net_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic rst0, rst_mid, rst_a;
    assign rst_a = rst0 | rst_mid;

    // Instance A
    logic        in_valid_a, start_a;
    logic [15:0] in_abcd_a;
    logic        out_valid_a, busy_a, done_a;
    logic [3:0]  y_a;
    logic [6:0]  cnt_a;
    // Instance B
    logic        in_valid_b, start_b;
    logic [3:0]  in_abcd_b;
    logic        out_valid_b, busy_b, done_b;
    logic [0:0]  y_b;
    logic [4:0]  cnt_b;
    // Instance C
    logic        in_valid_c, start_c;
    logic [63:0] in_abcd_c;
    logic        out_valid_c, busy_c, done_c;
    logic [15:0] y_c;
    logic [8:0]  cnt_c;

    gate_net_pipe #(.LANES(4), .PIPE(2)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_abcd(in_abcd_a),
        .sweep_start(start_a), .out_valid(out_valid_a), .y(y_a),
        .sweep_busy(busy_a), .sweep_done(done_a), .ones_count(cnt_a));

    gate_net_pipe #(.LANES(1), .PIPE(1)) dut_b (
        .clk(clk), .rst(rst0), .in_valid(in_valid_b), .in_abcd(in_abcd_b),
        .sweep_start(start_b), .out_valid(out_valid_b), .y(y_b),
        .sweep_busy(busy_b), .sweep_done(done_b), .ones_count(cnt_b));

    gate_net_pipe #(.LANES(16), .PIPE(4)) dut_c (
        .clk(clk), .rst(rst0), .in_valid(in_valid_c), .in_abcd(in_abcd_c),
        .sweep_start(start_c), .out_valid(out_valid_c), .y(y_c),
        .sweep_busy(busy_c), .sweep_done(done_c), .ones_count(cnt_c));

    // Scoreboard queues
    logic [15:0] q_a[$], q_b[$], q_c[$];
    int          dc_a[$], dv_a[$], dc_b[$], dv_b[$], dc_c[$], dv_c[$];

    // Reference: y = 1 only when c = 0 and not (a and d)
    function automatic logic model_f(input logic [3:0] v);
        return ~v[1] & ~(v[3] & v[0]);
    endfunction

    function automatic logic [15:0] sweep_y(input int k, input int lanes);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 0; i < lanes; i++) r[i] = model_f(4'((k + i) % 16));
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event, expected none (cycle %0d)", nm, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented output against the scoreboard
    always @(negedge clk) begin
        if (!rst_a) begin
            if (out_valid_a) begin
                if (q_a.size() == 0) unexpected("a_out_valid");
                else chk("a_y", int'(y_a), int'(q_a.pop_front()));
            end
            if (done_a) begin
                if (dc_a.size() == 0) unexpected("a_sweep_done");
                else begin
                    chk("a_done_cycle", cyc, dc_a.pop_front());
                    chk("a_ones_count", int'(cnt_a), dv_a.pop_front());
                end
            end
        end
        if (!rst0) begin
            if (out_valid_b) begin
                if (q_b.size() == 0) unexpected("b_out_valid");
                else chk("b_y", int'(y_b), int'(q_b.pop_front()));
            end
            if (done_b) begin
                if (dc_b.size() == 0) unexpected("b_sweep_done");
                else begin
                    chk("b_done_cycle", cyc, dc_b.pop_front());
                    chk("b_ones_count", int'(cnt_b), dv_b.pop_front());
                end
            end
            if (out_valid_c) begin
                if (q_c.size() == 0) unexpected("c_out_valid");
                else chk("c_y", int'(y_c), int'(q_c.pop_front()));
            end
            if (done_c) begin
                if (dc_c.size() == 0) unexpected("c_sweep_done");
                else begin
                    chk("c_done_cycle", cyc, dc_c.pop_front());
                    chk("c_ones_count", int'(cnt_c), dv_c.pop_front());
                end
            end
        end
    end

    // Pulse sweep_start on A and queue its 16 results and done event
    task automatic do_sweep_a();
        start_a = 1'b1;
        dc_a.push_back(cyc + 16 + 2 + 1);
        dv_a.push_back(24);
        for (int k = 0; k < 16; k++) q_a.push_back(sweep_y(k, 4));
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string nm);
        int n;
        n = 0;
        while (busy_a && n < 40) begin
            step();
            n++;
        end
        if (busy_a) unexpected(nm);
        step();
    endtask

    logic [3:0] sv [5];
    logic       ev [5];
    int         n;

    initial begin
        sv = '{4'b0000, 4'b1001, 4'b0010, 4'b1100, 4'b1110};
        ev = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rst0 = 1'b1; rst_mid = 1'b0;
        in_valid_a = 1'b0; start_a = 1'b0; in_abcd_a = 16'd0;
        in_valid_b = 1'b0; start_b = 1'b0; in_abcd_b = 4'd0;
        in_valid_c = 1'b0; start_c = 1'b0; in_abcd_c = 64'd0;
        repeat (3) step();
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_y", int'(y_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_ones", int'(cnt_a), 0);
        rst0 = 1'b0;
        step();

        // Stream vectors, same vector on all four lanes
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1'b1;
            in_abcd_a  = {4{sv[i]}};
            q_a.push_back({12'd0, {4{ev[i]}}});
            step();
        end
        in_valid_a = 1'b0;
        repeat (4) step();
        chk("stream_drained", q_a.size(), 0);
        chk("y_hold", int'(y_a), 0);

        // Basic sweep
        do_sweep_a();
        chk("busy_after_start", int'(busy_a), 1);
        wait_idle_a("sweep1_timeout");
        chk("sweep1_y_drained", q_a.size(), 0);
        chk("sweep1_done_seen", dc_a.size(), 0);

        // Stream traffic leaves ones_count alone
        in_valid_a = 1'b1; in_abcd_a = 16'h0000; q_a.push_back(16'h000F);
        step();
        in_valid_a = 1'b0;
        repeat (3) step();
        chk("ones_hold_stream", int'(cnt_a), 24);

        // In-flight stream vectors around sweep start, mid-sweep noise
        in_valid_a = 1'b1; in_abcd_a = 16'h0000; q_a.push_back(16'h000F);
        step();
        in_abcd_a = {4{4'b1001}}; q_a.push_back(16'h0000);
        do_sweep_a();
        in_valid_a = 1'b0;
        repeat (5) step();
        in_valid_a = 1'b1; start_a = 1'b1; in_abcd_a = 16'h0000;
        repeat (2) step();
        in_valid_a = 1'b0; start_a = 1'b0;
        wait_idle_a("sweep2_timeout");
        repeat (5) step();
        chk("no_restart_busy", int'(busy_a), 0);
        chk("sweep2_y_drained", q_a.size(), 0);
        chk("sweep2_done_seen", dc_a.size(), 0);

        // Reset at ISSUE cycle 8
        do_sweep_a();
        repeat (8) step();
        rst_mid = 1'b1;
        step();
        q_a.delete(); dc_a.delete(); dv_a.delete();
        chk("midrst_out_valid", int'(out_valid_a), 0);
        chk("midrst_y", int'(y_a), 0);
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_done", int'(done_a), 0);
        chk("midrst_ones", int'(cnt_a), 0);
        rst_mid = 1'b0;
        step();
        do_sweep_a();
        wait_idle_a("sweep3_timeout");

        // Back-to-back sweeps, second start in the first IDLE cycle
        do_sweep_a();
        n = 0;
        while (!done_a && n < 40) begin
            step();
            n++;
        end
        if (!done_a) unexpected("b2b_done_timeout");
        step();
        chk("b2b_idle_busy", int'(busy_a), 0);
        chk("b2b_ones_between", int'(cnt_a), 24);
        do_sweep_a();
        wait_idle_a("sweep5_timeout");
        repeat (3) step();
        chk("b2b_ones_after", int'(cnt_a), 24);

        // Other geometries
        start_b = 1'b1; start_c = 1'b1;
        dc_b.push_back(cyc + 16 + 1 + 1); dv_b.push_back(6);
        dc_c.push_back(cyc + 16 + 4 + 1); dv_c.push_back(96);
        for (int k = 0; k < 16; k++) begin
            q_b.push_back(sweep_y(k, 1));
            q_c.push_back(sweep_y(k, 16));
        end
        step();
        start_b = 1'b0; start_c = 1'b0;
        repeat (30) step();

        chk("end_q_a", q_a.size(), 0);
        chk("end_dc_a", dc_a.size(), 0);
        chk("end_q_b", q_b.size(), 0);
        chk("end_dc_b", dc_b.size(), 0);
        chk("end_q_c", q_c.size(), 0);
        chk("end_dc_c", dc_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
